// File: rtl/pixel_ctrl_pkg.sv
// Shared types and defaults for the 2x2 pixel array sequencer.
package pixel_ctrl_pkg;

    localparam int CNT_W           = 8;
    localparam int DEF_ERASE_CYC   = 5;
    localparam int DEF_EXPOSE_CYC  = 255;
    localparam int DEF_CONV_CYC    = 255;
    localparam int DEF_READ_SETTLE = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_GAP,
        ST_READ1,
        ST_READ2
    } state_t;

    // Timer/counter terminal value for a phase lasting n cycles.
    function automatic logic [CNT_W-1:0] last_val(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; done flags the last cycle of a phase.
module phase_timer
    import pixel_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: every flop here takes the async reset; there is no memory array that could skip it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: erase, expose, ramp conversion, two-row readout.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int ERASE_CYC   = DEF_ERASE_CYC,
    parameter int EXPOSE_CYC  = DEF_EXPOSE_CYC,
    parameter int CONV_CYC    = DEF_CONV_CYC,
    parameter int READ_SETTLE = DEF_READ_SETTLE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             continuous,
    output logic             erase,
    output logic             expose,
    output logic             pix_reset,
    output logic             ramp_en,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_oe,
    output logic             read1,
    output logic             read2,
    input  logic [CNT_W-1:0] data_a,
    input  logic [CNT_W-1:0] data_b,
    output logic [15:0]      out_data,
    output logic             out_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CONV_LAST = last_val(CONV_CYC);

    state_t           state, state_nx;
    logic [CNT_W-1:0] conv_cnt;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             handshake;
    logic             in_read;

    assign handshake = out_valid && out_ready;
    assign in_read   = (state == ST_READ1) || (state == ST_READ2);
    assign cnt_out   = conv_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: defaults are assigned first so no path through the case can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start || continuous) state_nx = ST_ERASE;
            ST_ERASE:   if (tmr_done) state_nx = ST_EXPOSE;
            ST_EXPOSE:  if (tmr_done) state_nx = ST_CONVERT;
            ST_CONVERT: if (conv_cnt == CONV_LAST) state_nx = ST_GAP;
            ST_GAP:     state_nx = ST_READ1;
            ST_READ1:   if (handshake) state_nx = ST_READ2;
            ST_READ2:   if (handshake) state_nx = continuous ? ST_ERASE : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // The timer is reloaded on every state entry with that phase's length.
    always_comb begin
        tmr_load = (state_nx != state);
        tmr_val  = '0;
        case (state_nx)
            ST_ERASE:           tmr_val = last_val(ERASE_CYC);
            ST_EXPOSE:          tmr_val = last_val(EXPOSE_CYC);
            ST_READ1, ST_READ2: tmr_val = last_val(READ_SETTLE);
            default:            tmr_val = '0;
        endcase
    end

    phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (1'b1),
        .done     (tmr_done)
    );

    // Strobes decode the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            erase      <= 1'b0;
            pix_reset  <= 1'b0;
            expose     <= 1'b0;
            ramp_en    <= 1'b0;
            cnt_oe     <= 1'b0;
            read1      <= 1'b0;
            read2      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            conv_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= 1'b0;
        end else begin
            erase      <= (state_nx == ST_ERASE);
            pix_reset  <= (state_nx == ST_ERASE);
            expose     <= (state_nx == ST_EXPOSE);
            ramp_en    <= (state_nx == ST_CONVERT);
            cnt_oe     <= (state_nx == ST_CONVERT);
            read1      <= (state_nx == ST_READ1);
            read2      <= (state_nx == ST_READ2);
            busy       <= (state_nx != ST_IDLE);
            frame_done <= (state == ST_READ2) && handshake;

            // Restarting from zero on exit means a 256-step sweep never wraps.
            if (state == ST_CONVERT && state_nx == ST_CONVERT) begin
                conv_cnt <= conv_cnt + CNT_W'(1);
            end else begin
                conv_cnt <= '0;
            end

            if (handshake) begin
                out_valid <= 1'b0;
            end else if (in_read && tmr_done && !out_valid) begin
                out_valid <= 1'b1;
                out_data  <= {data_b, data_a};
                out_row   <= (state == ST_READ2);
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench: two sequencer instances (short sweep and full 256-step sweep)
// driven with randomized pixel data and backpressure, checked against phase-level expectations.
module tb_pixel_array_ctrl;

    localparam int E0 = 5,  X0 = 10, C0 = 16,  S0 = 2;
    localparam int E1 = 2,  X1 = 3,  C1 = 256, S1 = 1;

    logic       clk = 1'b0;
    logic       reset_n_s    [2];
    logic       start_s      [2];
    logic       continuous_s [2];
    logic       out_ready_s  [2];
    logic [7:0] data_a_s     [2];
    logic [7:0] data_b_s     [2];
    logic       erase_s      [2];
    logic       expose_s     [2];
    logic       pix_reset_s  [2];
    logic       ramp_en_s    [2];
    logic       cnt_oe_s     [2];
    logic       read1_s      [2];
    logic       read2_s      [2];
    logic       out_row_s    [2];
    logic       out_valid_s  [2];
    logic       busy_s       [2];
    logic       frame_done_s [2];
    logic [7:0] cnt_out_s    [2];
    logic [15:0] out_data_s  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pixel_array_ctrl #(
            .ERASE_CYC   (g == 0 ? E0 : E1),
            .EXPOSE_CYC  (g == 0 ? X0 : X1),
            .CONV_CYC    (g == 0 ? C0 : C1),
            .READ_SETTLE (g == 0 ? S0 : S1)
        ) dut (
            .clk        (clk),
            .reset_n    (reset_n_s[g]),
            .start      (start_s[g]),
            .continuous (continuous_s[g]),
            .erase      (erase_s[g]),
            .expose     (expose_s[g]),
            .pix_reset  (pix_reset_s[g]),
            .ramp_en    (ramp_en_s[g]),
            .cnt_out    (cnt_out_s[g]),
            .cnt_oe     (cnt_oe_s[g]),
            .read1      (read1_s[g]),
            .read2      (read2_s[g]),
            .data_a     (data_a_s[g]),
            .data_b     (data_b_s[g]),
            .out_data   (out_data_s[g]),
            .out_row    (out_row_s[g]),
            .out_valid  (out_valid_s[g]),
            .out_ready  (out_ready_s[g]),
            .busy       (busy_s[g]),
            .frame_done (frame_done_s[g])
        );
    end

    function automatic int e_cyc(input int k); return k == 0 ? E0 : E1; endfunction
    function automatic int x_cyc(input int k); return k == 0 ? X0 : X1; endfunction
    function automatic int c_cyc(input int k); return k == 0 ? C0 : C1; endfunction
    function automatic int s_cyc(input int k); return k == 0 ? S0 : S1; endfunction

    function automatic logic [6:0] strobes(input int k);
        return {erase_s[k], expose_s[k], pix_reset_s[k], ramp_en_s[k],
                cnt_oe_s[k], read1_s[k], read2_s[k]};
    endfunction

    function automatic logic [34:0] all_out(input int k);
        return {strobes(k), cnt_out_s[k], out_data_s[k], out_row_s[k],
                out_valid_s[k], busy_s[k], frame_done_s[k]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants watched on every falling edge while the instance is out of reset.
    logic        p_cnt_oe [2];
    logic        p_read   [2];
    logic        p_valid  [2];
    logic        p_ready  [2];
    logic        p_rst    [2];
    logic [15:0] p_data   [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset_n_s[k] === 1'b1 && p_rst[k] === 1'b1) begin
                if ($countones({erase_s[k], expose_s[k], ramp_en_s[k], read1_s[k], read2_s[k]}) > 1) viol++;
                if (pix_reset_s[k] !== erase_s[k]) viol++;
                if (cnt_oe_s[k] && (read1_s[k] || read2_s[k])) viol++;
                if (p_cnt_oe[k] && (read1_s[k] || read2_s[k])) viol++;
                if (p_read[k] && cnt_oe_s[k]) viol++;
                if (p_valid[k] && !p_ready[k] && (!out_valid_s[k] || out_data_s[k] !== p_data[k])) viol++;
            end
            p_rst[k]    = reset_n_s[k];
            p_cnt_oe[k] = cnt_oe_s[k];
            p_read[k]   = read1_s[k] || read2_s[k];
            p_valid[k]  = out_valid_s[k];
            p_ready[k]  = out_ready_s[k];
            p_data[k]   = out_data_s[k];
        end
    end

    // Entered in the first cycle of a row's READ phase; leaves in the cycle after the handshake.
    task automatic read_row(input int k, input bit row, input int bp,
                            input logic [7:0] a, input logic [7:0] b);
        int n;
        int bad;
        logic [15:0] exp;
        exp = {b, a};
        data_a_s[k] = a;
        data_b_s[k] = b;
        n   = 0;
        bad = 0;
        while (!out_valid_s[k] && n < 40) begin
            if (read1_s[k] !== !row || read2_s[k] !== row) bad++;
            n++;
            step();
        end
        check(row ? "row2_settle_len" : "row1_settle_len", n, s_cyc(k));
        check(row ? "row2_data" : "row1_data", out_data_s[k], exp);
        check(row ? "row2_out_row" : "row1_out_row", out_row_s[k], row);
        data_a_s[k] = ~a;
        data_b_s[k] = ~b;
        for (int i = 0; i < bp; i++) begin
            if (!out_valid_s[k] || out_data_s[k] !== exp) bad++;
            if (read1_s[k] !== !row || read2_s[k] !== row) bad++;
            step();
        end
        check(row ? "row2_strobe_hold" : "row1_strobe_hold", bad, 0);
        out_ready_s[k] = 1'b1;
        step();
        check(row ? "row2_valid_after_hs" : "row1_valid_after_hs", out_valid_s[k], 0);
        if (!row) check("row1_to_read2", {read1_s[k], read2_s[k]}, 2'b01);
    endtask

    // Entered in the first ERASE cycle of a frame.
    task automatic run_frame(input int k, input bit cont, input int bp, input bit mid_start,
                             input logic [7:0] a1, input logic [7:0] b1,
                             input logic [7:0] a2, input logic [7:0] b2);
        int n;
        int bad;
        logic [7:0] last;
        check("frame_busy", busy_s[k], 1);
        n = 0;
        while (erase_s[k] && n < 400) begin n++; step(); end
        check("erase_len", n, e_cyc(k));
        n = 0;
        while (expose_s[k] && n < 400) begin n++; step(); end
        check("expose_len", n, x_cyc(k));
        n    = 0;
        bad  = 0;
        last = '0;
        while (cnt_oe_s[k] && n < 400) begin
            if (cnt_out_s[k] !== 8'(n) || !ramp_en_s[k] || !busy_s[k]) bad++;
            last = cnt_out_s[k];
            start_s[k] = mid_start && (n == 3);
            n++;
            step();
        end
        start_s[k] = 1'b0;
        check("conv_len", n, c_cyc(k));
        check("conv_sequence_errors", bad, 0);
        check("conv_last_value", last, c_cyc(k) - 1);
        check("gap_strobes", strobes(k), 0);
        check("gap_busy", busy_s[k], 1);
        out_ready_s[k] = (bp == 0);
        step();
        read_row(k, 1'b0, bp, a1, b1);
        continuous_s[k] = cont;
        read_row(k, 1'b1, 0, a2, b2);
        check("frame_done_pulse", frame_done_s[k], 1);
        continuous_s[k] = 1'b0;
        out_ready_s[k]  = 1'b0;
        if (cont) begin
            check("continuous_erase", {erase_s[k], busy_s[k]}, 2'b11);
        end else begin
            check("end_idle", {strobes(k), busy_s[k]}, 0);
            step();
            check("frame_done_one_cycle", frame_done_s[k], 0);
            step();
            check("idle_stays", busy_s[k], 0);
        end
    endtask

    task automatic start_frame(input int k);
        start_s[k] = 1'b1;
        step();
        start_s[k] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit cont;
        bit prev_cont;
        for (int k = 0; k < 2; k++) begin
            reset_n_s[k]    = 1'b0;
            start_s[k]      = 1'b0;
            continuous_s[k] = 1'b0;
            out_ready_s[k]  = 1'b0;
            data_a_s[k]     = '0;
            data_b_s[k]     = '0;
        end
        step();
        step();
        check("reset_state_dut0", all_out(0), 0);
        check("reset_state_dut1", all_out(1), 0);
        reset_n_s[0] = 1'b1;
        reset_n_s[1] = 1'b1;
        step();
        step();
        check("idle_after_reset", busy_s[0], 0);

        // Directed frame with known pixel codes, chained into a continuous frame.
        start_frame(0);
        run_frame(0, 1'b1, 0, 1'b0, 8'h2A, 8'h15, 8'h33, 8'h44);
        // Backpressure on row 1 and a start pulse mid-conversion.
        run_frame(0, 1'b0, 7, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Asynchronous reset in the middle of conversion.
        start_frame(0);
        n = 0;
        while (!(cnt_oe_s[0] && cnt_out_s[0] == 8'd9) && n < 100) begin n++; step(); end
        check("reached_cnt9", cnt_out_s[0], 9);
        reset_n_s[0] = 1'b0;
        #1;
        check("async_reset_outputs", all_out(0), 0);
        step();
        step();
        reset_n_s[0] = 1'b1;
        step();
        check("post_reset_idle", {busy_s[0], frame_done_s[0]}, 0);
        start_frame(0);
        run_frame(0, 1'b0, $urandom_range(0, 3), 1'b0,
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Full 256-step sweep on the second instance.
        start_frame(1);
        run_frame(1, 1'b0, $urandom_range(0, 4), 1'b0,
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Random frames, occasionally chained with continuous mode.
        prev_cont = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cont = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!prev_cont) start_frame(0);
            run_frame(0, cont, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                      8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            prev_cont = cont;
        end

        check("invariant_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
Sequencer for the 2x2 pixel sensor array: drives the global ERASE/EXPOSE/RESET strobes, runs the shared 8-bit conversion counter onto the pixel data buses while the ramp sweeps, then reads rows 1 and 2 in turn. Captured pixel codes go out on a valid/ready stream. It sits between the array (through the top-level tri-state buffers) and the downstream readout logic.

Parameters:
ERASE_CYC, 5, cycles ERASE and RESET held high (1..255)
EXPOSE_CYC, 255, cycles EXPOSE held high (1..255)
CONV_CYC, 255, conversion counter steps (1..256); counter runs 0..CONV_CYC-1
READ_SETTLE, 2, cycles READx held high before DATA sampling (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame request; ignored unless in IDLE
continuous  in  1  when 1, start a new frame right after READ2 without a start
erase  out  1  to array ERASE
expose  out  1  to array EXPOSE
pix_reset  out  1  to array RESET (comparator latch reset)
ramp_en  out  1  enables the ramp generator
cnt_out  out  8  conversion counter value for DATA1..4 tri-state drivers
cnt_oe  out  1  tri-state enable for cnt_out onto DATA1..4
read1  out  1  to array READ1 (pixels 1,2)
read2  out  1  to array READ2 (pixels 3,4)
data_a  in  8  sampled DATA1 (row1) / DATA3 (row2)
data_b  in  8  sampled DATA2 (row1) / DATA4 (row2)
out_data  out  16  {data_b, data_a} of the current row
out_row  out  1  0 = row1, 1 = row2
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse on READ2 handshake completion

Behaviour:
- reset_n low: state IDLE immediately; all outputs 0, internal counters 0. Reset mid-frame aborts the frame with no frame_done.
- All outputs registered; decoded from state and counters.
- States: IDLE, ERASE, EXPOSE, CONVERT, GAP, READ1, READ2.
- IDLE: leave to ERASE on the cycle after start=1 or continuous=1.
- ERASE: erase=1, pix_reset=1 for exactly ERASE_CYC cycles -> EXPOSE.
- EXPOSE: expose=1 for exactly EXPOSE_CYC cycles -> CONVERT.
- CONVERT: ramp_en=1, cnt_oe=1; cnt_out=0 in the first cycle, +1 each cycle; after the cycle showing CONV_CYC-1 -> GAP. The counter never wraps within a frame (CONV_CYC=256 ends at 255).
- GAP: one cycle, all strobes 0 and cnt_oe=0. Bus turnaround so that cnt_oe and read1/read2 are never high in the same or adjacent cycles.
- READ1: read1=1. After READ_SETTLE cycles, sample data_a/data_b into out_data, out_row=0, out_valid=1. Hold read1, out_data and out_valid until out_valid&&out_ready; then out_valid=0 and go to READ2 the next cycle.
- READ2: same, with read2=1 and out_row=1. On handshake: frame_done=1 for one cycle; next state ERASE if continuous=1, else IDLE.
- out_valid never drops without a handshake. out_data is stable while out_valid=1. If out_ready is high in the first valid cycle, the handshake completes in that cycle.
- start while busy is ignored (not queued). continuous is sampled only at the READ2 handshake and in IDLE.
- Invariants: at most one of {erase, expose, ramp_en, read1, read2} is high, except pix_reset, which tracks erase. read1 and read2 are mutually exclusive.

Decomposition:
- Package pixel_ctrl_pkg: state enum typedef, CNT_W=8, default cycle constants.
- One sub-module: phase_timer, a loadable down-counter with a done flag, reused per state. The conversion counter stays in the top-level module.

Test Plan:
- ERASE_CYC=5, EXPOSE_CYC=10, CONV_CYC=16, start pulse -> erase high exactly 5 cycles, then expose 10, then cnt_out 0..15 with cnt_oe=1; GAP cycle has all strobes 0.
- Row readout with out_ready=1, data_a=8'h2A, data_b=8'h15 during READ1 -> out_data=16'h152A, out_row=0 valid after READ_SETTLE. Row2 with 8'h33/8'h44 -> 16'h4433, out_row=1, frame_done pulse.
- Backpressure: out_ready=0 for 7 cycles in READ1 -> read1 and out_data held steady, out_valid stays 1, no READ2 until the handshake.
- continuous=1 -> ERASE starts the cycle after the READ2 handshake with no IDLE gap. continuous=0 -> IDLE, busy=0. A start pulse mid-CONVERT has no effect.
- reset_n asserted mid-CONVERT at cnt_out=9 -> all outputs 0 asynchronously, IDLE. After release, start runs a full frame from cnt_out=0.
- CONV_CYC=256 -> cnt_out reaches 8'hFF, no wrap to 0, then GAP. Assertion: cnt_oe&&(read1||read2) never true across all runs.
